// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART transmitter between
//                NUM_REQ byte producers. Latches the winning byte, runs the
//                start/busy handshake and keeps tx_data stable for the frame.
//                All logic is in the baud_clk domain.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_REQ    : number of requesters (2..8)
//    GAP_CYCLES : idle baud cycles inserted after each frame (0..15)
//    START_TMO  : baud cycles allowed from tx_start to tx_busy high (>= 1)
//  Ports
//    baud_clk   in   baud-rate clock, rising edge
//    reset_n    in   asynchronous active-low reset
//    req        in   req[i]=1: requester i has a byte, held until ack[i]
//    req_data   in   byte of requester i at [8*i+7:8*i]
//    ack        out  one-cycle pulse, byte of requester i latched
//    tx_data    out  byte to the transmitter, stable from latch to frame end
//    tx_start   out  start strobe to the transmitter
//    tx_busy    in   busy flag from the transmitter
//    grant_id   out  index of the requester owning the current frame
//    active     out  high from latch until return to idle
//    tmo_err    out  sticky start-timeout flag, cleared only by reset
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 1,
    parameter int START_TMO  = 4
) (
    input  logic                       baud_clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       tmo_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMO_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;

    // Pointer value out of reset: searching starts at requester 0.
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);
    // Terminal counts; the counters start at 0 on entry to their state.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(START_TMO - 1);
    localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]         state_q,    state_d;
    logic [ID_W-1:0]    last_q,     last_d;
    logic [ID_W-1:0]    grant_q,    grant_d;
    logic [7:0]         tx_data_q,  tx_data_d;
    logic [NUM_REQ-1:0] ack_q,      ack_d;
    logic               start_q,    start_d;
    logic               active_q,   active_d;
    logic               tmo_err_q,  tmo_err_d;
    logic [TMO_W-1:0]   tmo_cnt_q,  tmo_cnt_d;
    logic [3:0]         gap_cnt_q,  gap_cnt_d;

    // ------------------------------------------------------------------------
    // Round-robin search: candidates are visited in the order last+1,
    // last+2, ... (mod NUM_REQ); the first asserted request wins.
    // ------------------------------------------------------------------------
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        ack_d     = '0;
        start_d   = start_q;
        active_d  = active_q;
        tmo_err_d = tmo_err_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                // tx_data is only ever loaded here, so it stays frozen for
                // the whole frame including the trailing gap.
                if (win_found) begin
                    tx_data_d     = req_data[{win_id, 3'b000} +: 8];
                    grant_d       = win_id;
                    last_d        = win_id;
                    ack_d[win_id] = 1'b1;
                    start_d       = 1'b1;
                    active_d      = 1'b1;
                    tmo_cnt_d     = '0;
                    state_d       = S_START;
                end
            end

            S_START: begin
                // A busy seen on the terminal-count edge still wins over the
                // timeout: the transmitter has accepted the byte.
                if (tx_busy) begin
                    start_d = 1'b0;
                    state_d = S_BUSY;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    start_d   = 1'b0;
                    tmo_err_d = 1'b1;
                    active_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            S_BUSY: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                start_d  = 1'b0;
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers. Reset is asynchronous so tx_start drops immediately
    // when reset hits mid-frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_INIT;
            grant_q   <= '0;
            tx_data_q <= '0;
            ack_q     <= '0;
            start_q   <= 1'b0;
            active_q  <= 1'b0;
            tmo_err_q <= 1'b0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            active_q  <= active_d;
            tmo_err_q <= tmo_err_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign ack      = ack_q;
    assign tx_data  = tx_data_q;
    assign tx_start = start_q;
    assign grant_id = grant_q;
    assign active   = active_q;
    assign tmo_err  = tmo_err_q;

endmodule
`default_nettype wire
